// File: rtl/prog_freq_divider.sv
// prog_freq_divider: multi-channel runtime-programmable divider with pulse/square outputs,
// shadowed config that only takes effect at period boundaries, and a global phase-sync restart.
module prog_freq_divider #(
  parameter int CHANNELS        = 4,
  parameter int DIV_WIDTH       = 16,
  parameter int DEFAULT_DIVISOR = 2,
  parameter int DEFAULT_MODE    = 0,
  localparam int CW             = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 wr_en_i,
  input  logic [CW-1:0]        wr_channel_i,
  input  logic [DIV_WIDTH-1:0] wr_divisor_i,
  input  logic                 wr_mode_i,
  input  logic [CHANNELS-1:0]  enable_i,
  input  logic                 sync_i,
  output logic [CHANNELS-1:0]  clk_output_o,
  output logic [CHANNELS-1:0]  tick_o,
  output logic [CHANNELS-1:0]  pending_o
);
  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIVISOR);
  localparam logic DEF_MODE = 1'(DEFAULT_MODE);
  if (CHANNELS < 1 || DIV_WIDTH < 1 ||
      (DIV_WIDTH < 64 && 64'(DEFAULT_DIVISOR) >= (64'd1 << DIV_WIDTH))) begin : g_bad_params
    $error("prog_freq_divider: illegal CHANNELS, DIV_WIDTH or DEFAULT_DIVISOR");
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d, sdiv_q, sdiv_d, e, h, c_nxt;
    logic mode_q, mode_d, smode_q, smode_d, pend_q, pend_d, clk_q, clk_d, tick_q, tick_d;
    logic run, wr, ld;
    // Shadow loads at a period boundary or whenever the channel is held idle; a same-edge
    // write still lands in the shadow so the newest config is never lost.
    always_comb begin
      e = div_q == '0 ? ONE : div_q;
      h = e - (e >> 1);
      c_nxt = cnt_q >= e - ONE ? '0 : cnt_q + ONE;
      run = enable_i[i] && !sync_i;
      wr = wr_en_i && wr_channel_i == CW'(i);
      ld = pend_q && (!run || c_nxt == '0);
      cnt_d = run ? c_nxt : '0;
      tick_d = run && c_nxt == '0;
      clk_d = run && (mode_q ? c_nxt < h : c_nxt == '0);
      div_d = ld ? sdiv_q : div_q;
      mode_d = ld ? smode_q : mode_q;
      sdiv_d = wr ? wr_divisor_i : sdiv_q;
      smode_d = wr ? wr_mode_i : smode_q;
      pend_d = wr || (pend_q && !ld);
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        cnt_q <= '0;
        div_q <= DEF_DIV;
        mode_q <= DEF_MODE;
        sdiv_q <= DEF_DIV;
        smode_q <= DEF_MODE;
        pend_q <= 1'b0;
        clk_q <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        div_q <= div_d;
        mode_q <= mode_d;
        sdiv_q <= sdiv_d;
        smode_q <= smode_d;
        pend_q <= pend_d;
        clk_q <= clk_d;
        tick_q <= tick_d;
      end
    end
    assign clk_output_o[i] = clk_q;
    assign tick_o[i] = tick_q;
    assign pending_o[i] = pend_q;
  end
endmodule
